// File: rtl/equiv_sweep_checker_pkg.sv
// Shared definitions for the equivalence sweep checker.
//   sweep_state_e : FSM state encoding shared by the top level and the bench
//   SETTLE_W      : width of the settle counter (SETTLE up to 15)
package equiv_sweep_checker_pkg;

    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StFinish = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_counter.sv
// Settle-interval counter: clearable, incrementing, with a terminal-count flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one
//   cnt        : current count
//   tc         : high when cnt == Limit-1, i.e. the last cycle of the interval
module sweep_settle_counter
    import equiv_sweep_checker_pkg::*;
#(
    parameter int unsigned Limit = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [SETTLE_W-1:0] cnt,
    output logic                tc
);

    localparam logic [SETTLE_W-1:0] TcVal = SETTLE_W'(Limit - 1);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TcVal);

endmodule

// File: rtl/equiv_sweep_checker.sv
// Exhaustive equivalence checker for a small combinational block. Walks every
// input vector, holds each for SETTLE cycles, then compares the unsimplified
// (s_a) and simplified (s_b) outputs and accumulates the mismatch results.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a sweep (only honoured while idle)
//   vec         : stimulus to the block under test, MSB is the first input
//   s_a, s_b    : outputs of the two forms being compared
//   busy        : sweep in progress (drive and sample phases)
//   done        : one-cycle completion pulse
//   pass        : last sweep had no mismatches, held until the next start
//   err_cnt     : mismatching vectors in the current/last sweep
//   fail_seen   : at least one mismatch seen in this sweep
//   first_fail  : vector of the first mismatch (valid when fail_seen)
module equiv_sweep_checker
    import equiv_sweep_checker_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            s_a,
    input  logic            s_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            fail_seen,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN-1:0] VecLast = '1;

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fail_seen_q, fail_seen_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;

    logic                cnt_clr, cnt_inc, cnt_tc;
    logic [SETTLE_W-1:0] cnt_unused;
    logic                mismatch;

    sweep_settle_counter #(
        .Limit (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt_unused),
        .tc    (cnt_tc)
    );

    assign mismatch = s_a ^ s_b;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StDrive;
                    vec_d        = '0;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                    cnt_clr      = 1'b1;
                end
            end
            StDrive: begin
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                cnt_clr = 1'b1;
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = vec_q;
                    end
                end
                if (vec_q == VecLast) begin
                    state_d = StFinish;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Include the final vector's result so pass lines up with done.
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    state_d = StDrive;
                    vec_d   = vec_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Bench for equiv_sweep_checker: a main instance (N_IN=3, SETTLE=1) driven by a
// behavioural block under test with selectable faults, plus a second instance
// (N_IN=2, SETTLE=3) for the alternate timing. Expected sweep results are
// pushed to a scoreboard when a sweep is started and popped on done.
module tb_equiv_sweep_checker;

    typedef struct packed {
        logic [3:0] err;
        logic       fs;
        logic [2:0] ff;
        logic       pass;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] vec;
    logic       s_a, s_b;
    logic       busy, done, pass, fail_seen;
    logic [3:0] err_cnt;
    logic [2:0] first_fail;

    logic       start2;
    logic [1:0] vec2;
    logic       s_a2, s_b2;
    logic       busy2, done2, pass2, fail_seen2;
    logic [2:0] err_cnt2;
    logic [1:0] first_fail2;

    int   mode;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    exp_t sb2_q[$];

    equiv_sweep_checker #(
        .N_IN   (3),
        .SETTLE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec        (vec),
        .s_a        (s_a),
        .s_b        (s_b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_seen  (fail_seen),
        .first_fail (first_fail)
    );

    equiv_sweep_checker #(
        .N_IN   (2),
        .SETTLE (3)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .vec        (vec2),
        .s_a        (s_a2),
        .s_b        (s_b2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_cnt    (err_cnt2),
        .fail_seen  (fail_seen2),
        .first_fail (first_fail2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Block under test: x|y in both forms, with optional injected differences.
    always_comb begin
        s_a = vec[2] | vec[1];
        s_b = s_a;
        if (mode == 1 && vec == 3'd5) s_b = ~s_a;
        if (mode == 2) begin
            s_a = 1'b1;
            s_b = 1'b0;
        end
    end

    assign s_a2 = vec2[0];
    assign s_b2 = vec2[0];

    function automatic exp_t compute_exp(input int m);
        exp_t e;
        logic a, b;
        e = '0;
        for (int v = 0; v < 8; v++) begin
            a = (v[2] | v[1]);
            b = a;
            if (m == 1 && v == 5) b = ~a;
            if (m == 2) begin
                a = 1'b1;
                b = 1'b0;
            end
            if (a != b) begin
                if (!e.fs) begin
                    e.fs = 1'b1;
                    e.ff = 3'(v);
                end
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input int m, input bit restart_pulses);
        exp_t e;
        int   busy_n, done_k, bad_vec, extra_done, extra_busy;
        busy_n  = 0;
        done_k  = 0;
        bad_vec = 0;
        mode    = m;
        sb_q.push_back(compute_exp(m));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = restart_pulses && (k == 5 || k == 10);
            if (busy) begin
                busy_n++;
                if (vec !== 3'((k - 1) / 2)) bad_vec++;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        check_eq("busy_cycles", 32'(busy_n), 32'd16);
        check_eq("done_cycle", 32'(done_k), 32'd17);
        check_eq("vec_seq", 32'(bad_vec), 32'd0);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        if (done_k != 0) begin
            check_eq("err_cnt", 32'(err_cnt), 32'(e.err));
            check_eq("fail_seen", 32'(fail_seen), 32'(e.fs));
            if (e.fs) check_eq("first_fail", 32'(first_fail), 32'(e.ff));
            check_eq("pass", 32'(pass), 32'(e.pass));
            check_eq("busy_at_done", 32'(busy), 32'd0);
            check_eq("vec_at_done", 32'(vec), 32'd0);
        end
        extra_done = 0;
        extra_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check_eq("extra_done", 32'(extra_done), 32'd0);
        check_eq("idle_after", 32'(extra_busy), 32'd0);
        check_eq("pass_hold", 32'(pass), 32'(e.pass));
    endtask

    task automatic run_sweep2();
        exp_t e;
        int   busy_n, done_k, bad_vec;
        busy_n  = 0;
        done_k  = 0;
        bad_vec = 0;
        sb2_q.push_back('{err: 4'd0, fs: 1'b0, ff: 3'd0, pass: 1'b1});
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy2) begin
                busy_n++;
                if (vec2 !== 2'((k - 1) / 4)) bad_vec++;
            end
            if (done2) begin
                done_k = k;
                break;
            end
        end
        check_eq("s3_busy_cycles", 32'(busy_n), 32'd16);
        check_eq("s3_done_cycle", 32'(done_k), 32'd17);
        check_eq("s3_vec_seq", 32'(bad_vec), 32'd0);
        e = sb2_q.pop_front();
        if (done_k != 0) begin
            check_eq("s3_err_cnt", 32'(err_cnt2), 32'(e.err));
            check_eq("s3_pass", 32'(pass2), 32'(e.pass));
        end
    endtask

    task automatic reset_mid_sweep();
        int dones;
        dones = 0;
        mode  = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_vec", 32'(vec), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_fail_seen", 32'(fail_seen), 32'd0);
        check_eq("rst_first_fail", 32'(first_fail), 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check_eq("rst_no_done", 32'(dones), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode    = 0;
        start   = 1'b0;
        start2  = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_eq("reset_vec", 32'(vec), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_pass", 32'(pass), 32'd0);
        check_eq("reset_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("reset_fail_seen", 32'(fail_seen), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(0, 1'b1);
        reset_mid_sweep();
        run_sweep(0, 1'b0);
        run_sweep2();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
- Sequential stimulus/response engine for the team's combinational boolean-expression blocks.
- Sweeps every input combination of a DUT onto `vec`, waits a settle interval, then samples two DUT outputs: the unsimplified form on `s_a` and the simplified form on `s_b`.
- Counts mismatches and reports pass/fail, replacing hand-written per-vector display checks with a synthesizable equivalence checker.

Parameters:
- N_IN, 3, number of DUT inputs; the sweep covers 2^N_IN vectors, 0 to 2^N_IN-1.
- SETTLE, 1, cycles `vec` is held before sampling; legal range 1 to 15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- vec  output  N_IN  stimulus to the DUT inputs; bit N_IN-1 drives the first input (x)
- s_a  input  1  DUT output, unsimplified expression
- s_b  input  1  DUT output, simplified expression
- busy  output  1  high from the first DRIVE cycle through the last SAMPLE cycle
- done  output  1  one-cycle pulse when the sweep completes
- pass  output  1  high when the completed sweep had zero mismatches; held until the next start
- err_cnt  output  N_IN+1  number of mismatching vectors in the current or last sweep
- fail_seen  output  1  set on the first mismatch of a sweep
- first_fail  output  N_IN  vector of the first mismatch; valid only when fail_seen=1

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. All outputs are 0: vec, busy, done, pass, err_cnt, fail_seen, first_fail, and the settle counter.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No done pulse is produced.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE, start=1: next cycle enters DRIVE. On that edge: vec=0, err_cnt=0, fail_seen=0, first_fail=0, pass=0, settle counter=0.
- DRIVE: busy=1 and vec held. The counter increments each cycle. After SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE (1 cycle, busy=1): mismatch = (s_a != s_b).
  - On mismatch: err_cnt increments on the clock edge.
  - On the first mismatch of the sweep: fail_seen=1 and first_fail=vec.
  - If vec == 2^N_IN-1, go to FINISH. Otherwise vec increments and the state returns to DRIVE with the counter cleared.
- FINISH (1 cycle): busy=0, done=1, pass=(err_cnt==0), vec returns to 0, then the state returns to IDLE.
- Timing: busy stays high for exactly 2^N_IN*(SETTLE+1) cycles. For N_IN=3, SETTLE=1 that is 16 cycles, and done is high in the 17th cycle after the start edge.
- err_cnt cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- The final vector (all ones) is compared before FINISH.
- start while busy, or during FINISH, is ignored. Holding start high in IDLE starts a new sweep immediately after FINISH.
- A start arriving in the same cycle as reset release is ignored, because the reset edge dominates.
- Outputs are registered. s_a and s_b are sampled only in SAMPLE.
- An X/Z on s_a or s_b is a bench error. RTL behaviour is defined only for 0/1 values.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, FINISH=2'd3) and a SETTLE_W=4 width constant.
- One natural sub-module, sweep_settle_counter: loadable/clearable counter with a terminal-count flag.
- The FSM, vector register, and result registers stay in the top level.

Test Plan:
- Tie s_a=s_b to the DUT output x|y (vec[2]|vec[1]), pulse start -> busy high for 16 cycles, done in cycle 17, pass=1, err_cnt=0, fail_seen=0.
- Force s_b=~s_a only while vec==3'd5 -> err_cnt=1, fail_seen=1, first_fail=3'd5, pass=0.
- Drive s_a=1, s_b=0 constantly -> err_cnt=4'd8, first_fail=3'd0, pass=0.
- Pulse start again at cycles 5 and 10 of a running sweep -> no restart; total busy still 16 cycles; exactly one done pulse.
- Assert rst_n=0 at cycle 7 of a sweep -> all outputs 0 within the same cycle; no done pulse; a later start gives a normal 16-cycle sweep.
- SETTLE=3, N_IN=2 -> busy for 16 cycles; vec changes every 4 cycles in the sequence 0,1,2,3.
